// File: rtl/topk_mig_responder.sv
// ============================================================================
// Module   : topk_mig_responder
// Purpose  : Responder side of the hot-page query/migration handshake.
//            Keeps the TOP_K hottest addresses from the sketch estimate
//            stream in a sorted table (descending count, valid slots packed
//            from slot 0). On an accepted query the table is snapshotted
//            into a drain buffer, cleared, and the snapshot is streamed out
//            hottest first over the mig_addr handshake.
// Ports    : clk, rstn (sync, active-low)
//            upd_en/upd_addr/upd_cnt   - estimate updates, no backpressure
//            query_en / query_ready    - query request / accept window
//            mig_addr_en/mig_addr/mig_addr_ready - migration address stream
//            stat_mig_cnt [15:0]       - handshake count, saturating
//                                        (only with TOPK_MIG_STATS_EN)
// Options  : `define TOPK_MIG_STATS_EN adds the stat_mig_cnt counter/port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module topk_mig_responder #(
   parameter int TOP_K     = 5,
   parameter int ADDR_SIZE = 28,
   parameter int CNT_SIZE  = 13
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 upd_en,
   input  logic [ADDR_SIZE-1:0] upd_addr,
   input  logic [CNT_SIZE-1:0]  upd_cnt,
   input  logic                 query_en,
   output logic                 query_ready,
   output logic                 mig_addr_en,
   output logic [ADDR_SIZE-1:0] mig_addr,
   input  logic                 mig_addr_ready
`ifdef TOPK_MIG_STATS_EN
   ,
   output logic [15:0]          stat_mig_cnt
`endif
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Live table
   logic [TOP_K-1:0]     r_vld;
   logic [ADDR_SIZE-1:0] r_addr [TOP_K];
   logic [CNT_SIZE-1:0]  r_cnt  [TOP_K];

   // Drain buffer; slot 0 is the output register
   logic [TOP_K-1:0]     r_dvld;
   logic [ADDR_SIZE-1:0] r_daddr [TOP_K];

   logic                 w_query_acc;
   logic                 w_hs;
   logic [TOP_K-1:0]     w_base_vld;
   logic [TOP_K-1:0]     w_hit;
   logic [TOP_K-1:0]     w_ge;
   logic [TOP_K-1:0]     w_above_ge;
   logic [TOP_K-1:0]     w_upto_h;
   logic [TOP_K-1:0]     w_take_new;
   logic [TOP_K-1:0]     w_shift;
   logic                 w_any_hit;
   logic                 w_ins;
   logic [TOP_K-1:0]     w_prv_vld;
   logic [ADDR_SIZE-1:0] w_prv_addr [TOP_K];
   logic [CNT_SIZE-1:0]  w_prv_cnt  [TOP_K];
   logic [TOP_K-1:0]     w_nxt_vld;
   logic [ADDR_SIZE-1:0] w_nxt_addr [TOP_K];
   logic [CNT_SIZE-1:0]  w_nxt_cnt  [TOP_K];

   assign w_query_acc = (r_state == S_IDLE) && query_en;
   assign w_hs        = mig_addr_en && mig_addr_ready;

   // An update that coincides with an accepted query lands in the freshly
   // cleared table, so the update logic works on an all-invalid base.
   assign w_base_vld  = w_query_acc ? '0 : r_vld;

   // ------------------------------------------------------------------------
   // Update insertion.
   // w_ge[i] marks slots that stay above the new entry (cnt >= upd_cnt, so
   // ties keep the older entry on top). Because the table is sorted and
   // packed, w_ge is a prefix of ones; the first zero is the insert point.
   // Slots between the insert point and the vacated slot (the hit slot, or
   // the last slot on a miss) shift down by one.
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < TOP_K; gi++) begin : g_slot
      assign w_hit[gi] = w_base_vld[gi] && (r_addr[gi] == upd_addr);
      assign w_ge[gi]  = w_base_vld[gi] && (r_cnt[gi] >= upd_cnt);

      if (gi == 0) begin : g_head
         assign w_above_ge[gi] = 1'b1;
         assign w_prv_vld[gi]  = 1'b0;
         assign w_prv_addr[gi] = '0;
         assign w_prv_cnt[gi]  = '0;
      end else begin : g_body
         assign w_above_ge[gi] = w_ge[gi-1];
         assign w_prv_vld[gi]  = w_base_vld[gi-1];
         assign w_prv_addr[gi] = r_addr[gi-1];
         assign w_prv_cnt[gi]  = r_cnt[gi-1];
      end

      assign w_take_new[gi] = w_ins && !w_ge[gi] && w_above_ge[gi];
      assign w_shift[gi]    = w_ins && !w_ge[gi] && !w_above_ge[gi] && w_upto_h[gi];

      assign w_nxt_vld[gi]  = w_take_new[gi] ? 1'b1     :
                              w_shift[gi]    ? w_prv_vld[gi] : w_base_vld[gi];
      assign w_nxt_addr[gi] = w_take_new[gi] ? upd_addr :
                              w_shift[gi]    ? w_prv_addr[gi] : r_addr[gi];
      assign w_nxt_cnt[gi]  = w_take_new[gi] ? upd_cnt  :
                              w_shift[gi]    ? w_prv_cnt[gi] : r_cnt[gi];
   end

   assign w_any_hit = |w_hit;

   // A hit moves only when its count grows (hit slot not >=); a miss enters
   // only if the last slot is free or colder than the new count.
   assign w_ins = upd_en && (upd_cnt != '0) &&
                  (w_any_hit ? !(|(w_hit & w_ge)) : !w_ge[TOP_K-1]);

   // w_upto_h[i]: slot i is at or above the vacated slot.
   always_comb begin : p_upto
      logic l_seen;
      l_seen   = 1'b0;
      w_upto_h = '0;
      for (int i = TOP_K - 1; i >= 0; i--) begin
         l_seen      = l_seen | w_hit[i];
         w_upto_h[i] = l_seen | !w_any_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_vld <= '0;
      end else begin
         r_vld <= w_nxt_vld;
      end
   end

   // Payload is qualified by r_vld, so it needs no reset.
   always_ff @(posedge clk) begin
      r_addr <= w_nxt_addr;
      r_cnt  <= w_nxt_cnt;
   end

   // ------------------------------------------------------------------------
   // Drain buffer. Invalid slots are captured as zero so the head reads 0
   // whenever the buffer is exhausted.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_dvld <= '0;
         for (int i = 0; i < TOP_K; i++) begin
            r_daddr[i] <= '0;
         end
      end else if (w_query_acc) begin
         r_dvld <= r_vld;
         for (int i = 0; i < TOP_K; i++) begin
            r_daddr[i] <= r_vld[i] ? r_addr[i] : '0;
         end
      end else if (w_hs) begin
         r_dvld <= {1'b0, r_dvld[TOP_K-1:1]};
         for (int i = 0; i < TOP_K - 1; i++) begin
            r_daddr[i] <= r_daddr[i+1];
         end
         r_daddr[TOP_K-1] <= '0;
      end
   end

   assign mig_addr = r_daddr[0];

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      query_ready = 1'b0;
      mig_addr_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            query_ready = 1'b1;
            // An empty snapshot produces no stream at all.
            if (query_en && r_vld[0]) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            mig_addr_en = 1'b1;
            if (mig_addr_ready && !r_dvld[1]) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef TOPK_MIG_STATS_EN
   logic [15:0] r_stat_mig_cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stat_mig_cnt <= '0;
      end else if (w_hs && (r_stat_mig_cnt != 16'hFFFF)) begin
         r_stat_mig_cnt <= r_stat_mig_cnt + 16'd1;
      end
   end

   assign stat_mig_cnt = r_stat_mig_cnt;
`else
   // Statistics counter not built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_topk_mig_responder.sv
// ============================================================================
// Module   : tb_topk_mig_responder
// Purpose  : Self-checking bench for topk_mig_responder. A queue-based model
//            of the hot list and drain stream is compared against the DUT on
//            every cycle; directed scenarios pin the model with literal
//            expected drain sequences, then a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_topk_mig_responder;

   localparam int K  = 5;
   localparam int AW = 28;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rstn;
   logic          upd_en;
   logic [AW-1:0] upd_addr;
   logic [CW-1:0] upd_cnt;
   logic          query_en;
   logic          query_ready;
   logic          mig_addr_en;
   logic [AW-1:0] mig_addr;
   logic          mig_addr_ready;
`ifdef TOPK_MIG_STATS_EN
   logic [15:0]   stat_mig_cnt;
`endif

   always #5 clk = ~clk;

   topk_mig_responder #(.TOP_K(K), .ADDR_SIZE(AW), .CNT_SIZE(CW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .upd_en         (upd_en),
      .upd_addr       (upd_addr),
      .upd_cnt        (upd_cnt),
      .query_en       (query_en),
      .query_ready    (query_ready),
      .mig_addr_en    (mig_addr_en),
      .mig_addr       (mig_addr),
      .mig_addr_ready (mig_addr_ready)
`ifdef TOPK_MIG_STATS_EN
      ,
      .stat_mig_cnt   (stat_mig_cnt)
`endif
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [CW-1:0] c;
   } ent_t;

   ent_t          live[$];
   logic [AW-1:0] m_dq[$];
   logic [AW-1:0] got[$];
   int            m_stat = 0;
   int            n_chk  = 0;
   int            n_fail = 0;
   bit            chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hot-list rules: drop zero counts, a hit only ever raises its count,
   // a full list admits only counts above its coldest entry, and a new or
   // moved entry goes below entries of equal count.
   function automatic void m_upd(input logic [AW-1:0] a, input logic [CW-1:0] c);
      int   hit = -1;
      int   pos;
      ent_t e;
      if (c == 0) return;
      foreach (live[j]) if (live[j].a == a) hit = j;
      if (hit >= 0) begin
         if (c <= live[hit].c) return;
         live.delete(hit);
      end else if (live.size() == K) begin
         if (c <= live[K-1].c) return;
         void'(live.pop_back());
      end
      pos = live.size();
      for (int j = live.size() - 1; j >= 0; j--) if (live[j].c < c) pos = j;
      e.a = a;
      e.c = c;
      live.insert(pos, e);
   endfunction

   // Model advances on every active edge using the inputs present there.
   initial begin
      forever begin
         @(posedge clk);
         if (!rstn) begin
            live.delete();
            m_dq.delete();
            m_stat = 0;
         end else begin
            if (m_dq.size() != 0 && mig_addr_ready) begin
               void'(m_dq.pop_front());
               if (m_stat < 16'hFFFF) m_stat++;
            end else if (m_dq.size() == 0 && query_en) begin
               foreach (live[j]) m_dq.push_back(live[j].a);
               live.delete();
            end
            if (upd_en) m_upd(upd_addr, upd_cnt);
         end
      end
   end

   // Per-cycle comparison against the model, on the inactive edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("query_ready", {31'b0, query_ready}, {31'b0, m_dq.size() == 0});
            check("mig_addr_en", {31'b0, mig_addr_en}, {31'b0, m_dq.size() != 0});
            if (m_dq.size() != 0) check("mig_addr", {4'b0, mig_addr}, {4'b0, m_dq[0]});
`ifdef TOPK_MIG_STATS_EN
            check("stat_mig_cnt", {16'b0, stat_mig_cnt}, m_stat);
`endif
            if (mig_addr_en && mig_addr_ready && rstn) got.push_back(mig_addr);
         end
      end
   end

   task automatic drive(input bit ue, input logic [AW-1:0] a, input logic [CW-1:0] c, input bit q);
      upd_en   = ue;
      upd_addr = a;
      upd_cnt  = c;
      query_en = q;
      @(posedge clk);
      #2;
      upd_en   = 1'b0;
      query_en = 1'b0;
   endtask

   task automatic wait_idle(output int busy);
      busy = 0;
      @(negedge clk);
      while (query_ready !== 1'b1 && busy < 60) begin
         busy++;
         @(negedge clk);
      end
      if (busy >= 60) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: busy %0d cycles, limit 60", busy);
      end
      #1;
   endtask

   task automatic check_got(input string name, input logic [AW-1:0] exp[$]);
      check({name, "_len"}, got.size(), exp.size());
      foreach (exp[j]) begin
         if (j < got.size()) check(name, {4'b0, got[j]}, {4'b0, exp[j]});
      end
      got.delete();
   endtask

   initial begin
      logic [AW-1:0] exp_q[$];
      int            busy;

      rstn           = 1'b0;
      upd_en         = 1'b0;
      upd_addr       = '0;
      upd_cnt        = '0;
      query_en       = 1'b0;
      mig_addr_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk_on = 1'b1;
      rstn   = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_query_ready", {31'b0, query_ready}, 32'd1);
      check("rst_mig_addr_en", {31'b0, mig_addr_en}, 32'd0);
      check("rst_mig_addr", {4'b0, mig_addr}, 32'd0);
      @(posedge clk);
      #2;

      // Sorted drain, 3 entries in 3 cycles
      drive(1, 28'h100, 5, 0);
      drive(1, 28'h200, 9, 0);
      drive(1, 28'h300, 7, 0);
      drive(0, 0, 0, 1);
      wait_idle(busy);
      check("sorted_busy_cycles", busy, 32'd3);
      exp_q = '{28'h200, 28'h300, 28'h100};
      check_got("sorted", exp_q);
`ifdef TOPK_MIG_STATS_EN
      check("stat_after_3", {16'b0, stat_mig_cnt}, 32'd3);
`endif

      // Overflow
      drive(1, 28'h010, 10, 0);
      drive(1, 28'h020, 20, 0);
      drive(1, 28'h030, 30, 0);
      drive(1, 28'h040, 40, 0);
      drive(1, 28'h050, 50, 0);
      drive(1, 28'h600, 15, 0);
      drive(1, 28'h700, 5, 0);
      drive(0, 0, 0, 1);
      wait_idle(busy);
      exp_q = '{28'h050, 28'h040, 28'h030, 28'h020, 28'h600};
      check_got("overflow", exp_q);

      // Hit
      drive(1, 28'h100, 4, 0);
      drive(1, 28'h100, 3, 0);
      drive(1, 28'h200, 8, 0);
      drive(1, 28'h100, 12, 0);
      drive(0, 0, 0, 1);
      wait_idle(busy);
      exp_q = '{28'h100, 28'h200};
      check_got("hit", exp_q);

      // Backpressure then reset mid-drain
      drive(1, 28'h111, 5, 0);
      drive(1, 28'h222, 6, 0);
      mig_addr_ready = 1'b0;
      drive(0, 0, 0, 1);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("bp_hold_addr", {4'b0, mig_addr}, 32'h222);
         check("bp_hold_en", {31'b0, mig_addr_en}, 32'd1);
      end
      @(posedge clk);
      #2;
      rstn = 1'b0;
      @(posedge clk);
      #2;
      rstn           = 1'b1;
      mig_addr_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_en", {31'b0, mig_addr_en}, 32'd0);
      check("rst_mid_ready", {31'b0, query_ready}, 32'd1);
      @(posedge clk);
      #2;
      drive(0, 0, 0, 1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("post_rst_query_en", {31'b0, mig_addr_en}, 32'd0);
      end
      got.delete();

      // Empty query
      @(posedge clk);
      #2;
      drive(0, 0, 0, 1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("empty_query_en", {31'b0, mig_addr_en}, 32'd0);
      end
      @(posedge clk);
      #2;

      // Update colliding with an accepted query
      drive(1, 28'h500, 3, 0);
      drive(1, 28'h400, 6, 1);
      wait_idle(busy);
      exp_q = '{28'h500};
      check_got("collision_cur", exp_q);
      drive(0, 0, 0, 1);
      wait_idle(busy);
      exp_q = '{28'h400};
      check_got("collision_next", exp_q);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rstn           = ($urandom_range(0, 99) != 0);
         mig_addr_ready = ($urandom_range(0, 9) < 7);
         upd_en         = $urandom_range(0, 1);
         upd_addr       = AW'($urandom_range(1, 12)) << 4;
         upd_cnt        = CW'($urandom_range(0, 20));
         query_en       = ($urandom_range(0, 9) == 0);
         @(posedge clk);
         #2;
      end
      rstn     = 1'b1;
      upd_en   = 1'b0;
      query_en = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/topk_mig_responder.md
# topk_mig_responder

Responder side of the hot-page query/migration handshake. Tracks the TOP_K hottest addresses reported by the count-min sketch estimate stream in a small sorted table. When the rate-driven query controller raises `query_en`, the block snapshots the table and streams the addresses, hottest first, over the `mig_addr_en`/`mig_addr`/`mig_addr_ready` handshake. It sits between the sketch estimate pipeline and the query controller.

## Interface
- `TOP_K`, 5: number of tracked entries (2..16).
- `ADDR_SIZE`, 28: cache-line address width.
- `CNT_SIZE`, 13: estimate count width.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `upd_en`  in  1  estimate update valid (no backpressure; every asserted cycle is consumed).
- `upd_addr`  in  ADDR_SIZE  address of the update.
- `upd_cnt`  in  CNT_SIZE  sketch estimate for `upd_addr`.
- `query_en`  in  1  query request pulse from the query controller.
- `query_ready`  out  1  high when IDLE and a query can be accepted.
- `mig_addr_en`  out  1  migration address valid.
- `mig_addr`  out  ADDR_SIZE  migration address.
- `mig_addr_ready`  in  1  consumer accepts `mig_addr` this cycle.

## Operation
- **Live table:** TOP_K slots, each holding {valid, addr, cnt}. Slots are kept sorted by cnt, descending, with valid slots contiguous from slot 0.
- **Updates:** processed every cycle `upd_en`=1, in both states.
  - `upd_cnt`==0 is ignored.
  - **Hit** (valid slot with equal addr): if `upd_cnt` > stored cnt, replace the cnt and re-position the entry. Otherwise no change. The entry is never duplicated.
  - **Miss, free slot:** insert at the sorted position.
  - **Miss, table full:** insert only if `upd_cnt` > the cnt of the last slot. The last slot drops out.
  - **Ties:** a new or moved entry is placed below existing entries of equal cnt.
- **FSM states:** IDLE, DRAIN.
  - IDLE: `query_ready`=1. On `query_en`=1, copy the live table into the drain buffer and clear the live table in the same edge.
    - If the copy holds at least 1 valid entry, go to DRAIN.
    - If the copy is empty, stay in IDLE with no output.
  - `query_en` while in DRAIN is ignored (dropped, not queued).
  - DRAIN: `query_ready`=0. `mig_addr_en`=1 with `mig_addr` = the head of the drain buffer.
    - On `mig_addr_en`&&`mig_addr_ready`, shift the buffer up by one.
    - After the handshake of the last valid entry, return to IDLE.
    - `mig_addr`/`mig_addr_en` hold stable while `mig_addr_ready`=0.
- **Update in the same cycle as an accepted query:** the update is applied to the freshly cleared live table, not to the snapshot.
- **No arithmetic on counts:** compare only; no saturation logic is needed.

## Timing
- **Reset values:** state IDLE, all valid bits 0, `query_ready`=1, `mig_addr_en`=0, `mig_addr`=0.
- **Reset mid-DRAIN:** the drain is abandoned and both tables are cleared at the next edge.
- **Update latency:** an update at edge t is visible in the live table after t (1 cycle).
- **Query latency:** `query_en` sampled at edge t with `query_ready`=1 gives `mig_addr_en`=1 and the hottest address from t+1.
- **Throughput:** one address per cycle while `mig_addr_ready`=1. N entries drain in N cycles, and `query_ready` rises in the cycle after the last handshake.
- **Output register:** `mig_addr` is driven from a register (the drain buffer head), not from combinational logic.

## Configuration
- **`TOPK_MIG_STATS_EN` defined:** adds output `stat_mig_cnt` [15:0].
  - Increments on every `mig_addr` handshake and saturates at 16'hFFFF.
  - Reset value 0.
- **`TOPK_MIG_STATS_EN` undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Sorted drain:** after reset, updates (A=0x100,cnt 5), (B=0x200,cnt 9), (C=0x300,cnt 7), then `query_en` with `mig_addr_ready`=1 -> `mig_addr` 0x200, 0x300, 0x100 on 3 consecutive cycles, then `query_ready`=1.
- **Overflow:** with TOP_K=5, insert counts 10,20,30,40,50, then 15 at 0x600, then 5 at 0x700 -> the drain yields cnt order 50,40,30,20,15. The entry 0x700 and the entry with cnt 10 are absent.
- **Hit:** update 0x100 with cnt 4, then cnt 3, then cnt 12, alongside 0x200 with cnt 8 -> the drain is 0x100, 0x200, and 0x100 appears once.
- **Backpressure and reset:** hold `mig_addr_ready`=0 for 4 cycles in DRAIN -> `mig_addr` stays stable. Then assert `rstn`=0 -> `mig_addr_en`=0 and `query_ready`=1 the next cycle, and a following query yields no output.
- **Empty query and collision:** `query_en` on an empty table -> `mig_addr_en` never rises. An update of 0x400 with cnt 6 in the same cycle as an accepted query -> 0x400 is absent from the current drain and appears in the next one.
- **Stats (with `TOPK_MIG_STATS_EN`):** 3 drained entries -> `stat_mig_cnt`=3. Preloaded at 16'hFFFF -> stays at 16'hFFFF.
